dmi_uart_host: RTL and testbench

DMI_UART_HOST -- requirements
Module: dmi_uart_host

---
 rtl/dmi_uart_host.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dmi_uart_host.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_uart_host.sv
// -----------------------------------------------------------------------------
// dmi_uart_host
//
// Bridges a request/response register-access port onto a byte-oriented UART
// link. Each request becomes a frame: the escape byte, a command byte
// ({3'b010 write / 3'b001 read, 5-bit address}), then for writes the payload
// LSB first with every payload ESC byte doubled. Reads collect NBYTES
// unescaped bytes from the RX FIFO and return them on the response port. An
// escape followed by anything other than a second escape is a protocol error.
//
// Optional feature (macro DMI_UART_HOST_TIMEOUT_EN): a read that sits in the
// receive states for TIMEOUT_CYCLES cycles without a byte arriving completes
// with rsp_error_o=1. Without the macro a read waits indefinitely.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   req_write_i                1 = write, 0 = read
//   req_address_i              register address (zero-extended to 5 bits)
//   req_data_i                 write payload
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_data_o                 read data (0 for writes)
//   rsp_error_o                protocol error or timeout
//   tx_ready_i, we_o, dsend_o  UART TX byte interface (one-cycle strobe)
//   rx_empty_i, re_o, drec_i   UART RX FIFO, first-word fall-through
// -----------------------------------------------------------------------------
module dmi_uart_host #(
  parameter logic [7:0] ESC            = 8'hB1,
  parameter int         WIDTH          = 41,
  parameter int         ADDR_WIDTH     = 5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_address_i,
  input  logic [WIDTH-1:0]      req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_error_o,
  input  logic                  tx_ready_i,
  output logic                  we_o,
  output logic [7:0]            dsend_o,
  input  logic                  rx_empty_i,
  output logic                  re_o,
  input  logic [7:0]            drec_i
);

  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int PW     = NBYTES * 8;          // payload width padded to bytes
  localparam int CW     = $clog2(NBYTES + 1);  // byte counter width

  typedef enum logic [2:0] {
    IDLE,
    TX_ESC,
    TX_CMD,
    TX_DATA,
    TX_STUFF,
    RX_DATA,
    RX_ESC,
    RESPOND
  } state_t;

  state_t                state;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [WIDTH-1:0]      req_data;
  logic [CW-1:0]         byte_cnt;

  logic [CW-1:0]         cnt_next;
  logic                  last_byte;
  logic [CW+2:0]         byte_shift;
  logic [7:0]            tx_byte;
  logic [7:0]            cmd_byte;
  logic                  tx_fire;
  logic [WIDTH-1:0]      rx_merged;
  logic                  timeout_hit;

  // Counter saturates at NBYTES instead of wrapping.
  assign cnt_next   = (byte_cnt == CW'(NBYTES)) ? byte_cnt : byte_cnt + CW'(1);
  assign last_byte  = (cnt_next == CW'(NBYTES));
  assign byte_shift = {byte_cnt, 3'b000};

  // Payload byte selected by the counter; bits past WIDTH read as zero.
  assign tx_byte  = 8'(PW'(req_data) >> byte_shift);
  assign cmd_byte = {(req_write ? 3'b010 : 3'b001), 5'(req_address)};

  // A byte goes out only when the UART is ready and no strobe is in flight,
  // so the cycle after each we_o never issues another one.
  assign tx_fire = tx_ready_i && !we_o;

  // Insert the received byte at the current byte slot; bits beyond WIDTH of
  // the top byte fall off in the final truncation.
  assign rx_merged = WIDTH'((PW'(rsp_data_o) & ~(PW'(8'hFF) << byte_shift))
                            | (PW'(drec_i) << byte_shift));

`ifdef DMI_UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_cnt;

  assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent waiting in the receive states; any consumed byte
  // restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_cnt <= '0;
    end else if ((state == RX_DATA || state == RX_ESC) && !re_o) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end else begin
      timeout_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; blocking ones would make later reads in this block see the
  // new value and break the one-cycle strobe timing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      req_write   <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
      byte_cnt    <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_error_o <= 1'b0;
      we_o        <= 1'b0;
      dsend_o     <= '0;
      re_o        <= 1'b0;
    end else begin
      // Strobes fall back to zero unless a state raises them this cycle.
      we_o <= 1'b0;
      re_o <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_write   <= req_write_i;
            req_address <= req_address_i;
            req_data    <= req_data_i;
            byte_cnt    <= '0;
            rsp_data_o  <= '0;
            rsp_error_o <= 1'b0;
            req_ready_o <= 1'b0;
            state       <= TX_ESC;
          end
        end

        TX_ESC: begin
          if (tx_fire) begin
            we_o    <= 1'b1;
            dsend_o <= ESC;
            state   <= TX_CMD;
          end
        end

        // The command byte is never escaped even if it equals ESC.
        TX_CMD: begin
          if (tx_fire) begin
            we_o    <= 1'b1;
            dsend_o <= cmd_byte;
            state   <= req_write ? TX_DATA : RX_DATA;
          end
        end

        TX_DATA: begin
          if (tx_fire) begin
            we_o     <= 1'b1;
            dsend_o  <= tx_byte;
            byte_cnt <= cnt_next;
            if (tx_byte == ESC) begin
              state <= TX_STUFF;
            end else if (last_byte) begin
              state       <= RESPOND;
              rsp_valid_o <= 1'b1;
            end
          end
        end

        // Second copy of a payload ESC; the counter already points past it.
        TX_STUFF: begin
          if (tx_fire) begin
            we_o    <= 1'b1;
            dsend_o <= ESC;
            if (byte_cnt == CW'(NBYTES)) begin
              state       <= RESPOND;
              rsp_valid_o <= 1'b1;
            end else begin
              state <= TX_DATA;
            end
          end
        end

        // drec_i is consumed in the cycle re_o is high; the FIFO pops at the
        // end of that cycle.
        RX_DATA: begin
          if (re_o) begin
            if (drec_i == ESC) begin
              state <= RX_ESC;
            end else begin
              rsp_data_o <= rx_merged;
              byte_cnt   <= cnt_next;
              if (last_byte) begin
                state       <= RESPOND;
                rsp_valid_o <= 1'b1;
              end
            end
          end else if (!rx_empty_i) begin
            re_o <= 1'b1;
          end else if (timeout_hit) begin
            state       <= RESPOND;
            rsp_valid_o <= 1'b1;
            rsp_error_o <= 1'b1;
          end
        end

        RX_ESC: begin
          if (re_o) begin
            if (drec_i == ESC) begin
              rsp_data_o <= rx_merged;
              byte_cnt   <= cnt_next;
              if (last_byte) begin
                state       <= RESPOND;
                rsp_valid_o <= 1'b1;
              end else begin
                state <= RX_DATA;
              end
            end else begin
              // Bad escape sequence: keep the bytes gathered so far.
              state       <= RESPOND;
              rsp_valid_o <= 1'b1;
              rsp_error_o <= 1'b1;
            end
          end else if (!rx_empty_i) begin
            re_o <= 1'b1;
          end else if (timeout_hit) begin
            state       <= RESPOND;
            rsp_valid_o <= 1'b1;
            rsp_error_o <= 1'b1;
          end
        end

        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_uart_host.sv
// -----------------------------------------------------------------------------
// tb_dmi_uart_host
//
// Self-checking bench for dmi_uart_host. A table of directed frames is run
// first, followed by reset, wait/timeout and randomized transactions whose
// expected frames and responses come from a byte-level model of the
// framing and escaping rules. The UART is modelled as a TX byte collector
// and a first-word fall-through RX queue.
// -----------------------------------------------------------------------------
module tb_dmi_uart_host;

  localparam logic [7:0] ESC   = 8'hB1;
  localparam int         WIDTH = 41;
  localparam int         NB    = 6;
  localparam int         TO    = 100;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  logic [4:0]       req_address_i;
  logic [WIDTH-1:0] req_data_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_data_o;
  logic             rsp_error_o;
  logic             tx_ready_i = 1'b1;
  logic             we_o;
  logic [7:0]       dsend_o;
  logic             rx_empty_i = 1'b1;
  logic             re_o;
  logic [7:0]       drec_i = 8'h00;

  dmi_uart_host #(
    .ESC           (ESC),
    .WIDTH         (WIDTH),
    .ADDR_WIDTH    (5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_address_i(req_address_i),
    .req_data_i   (req_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_error_o  (rsp_error_o),
    .tx_ready_i   (tx_ready_i),
    .we_o         (we_o),
    .dsend_o      (dsend_o),
    .rx_empty_i   (rx_empty_i),
    .re_o         (re_o),
    .drec_i       (drec_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // UART model: collects TX strobes, serves RX bytes from a queue.
  // ---------------------------------------------------------------------------
  logic [7:0] tx_got [$];
  logic [7:0] rx_q   [$];
  logic [7:0] rx_pend[$];
  bit         rnd_ready  = 1'b0;
  bit         re_prev    = 1'b0;
  int         flush_gen  = 0;
  int         flush_seen = 0;

  always @(posedge clk) begin
    #1;
    if (flush_seen != flush_gen) begin
      rx_q.delete();
      flush_seen = flush_gen;
    end
    // The byte read in the previous cycle leaves the FIFO now.
    if (re_prev) begin
      check("re_nonempty", 64'(rx_q.size() != 0), 64'd1);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    re_prev = re_o;
    if (we_o) tx_got.push_back(dsend_o);
    if (rx_pend.size() != 0 && $urandom_range(0, 1) == 1)
      rx_q.push_back(rx_pend.pop_front());
    rx_empty_i = (rx_q.size() == 0);
    drec_i     = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    tx_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] exp_tx  [$];
  logic [7:0] rx_model[$];

  task automatic build_frame(input bit wr, input logic [4:0] a, input logic [WIDTH-1:0] d);
    logic [8*NB-1:0] p;
    logic [7:0]      b;
    p = {7'b0, d};
    exp_tx.delete();
    exp_tx.push_back(ESC);
    exp_tx.push_back({(wr ? 3'b010 : 3'b001), a});
    if (wr) begin
      for (int k = 0; k < NB; k++) begin
        b = p[8*k +: 8];
        exp_tx.push_back(b);
        if (b == ESC) exp_tx.push_back(ESC);
      end
    end
  endtask

  // Unescape the RX stream and accumulate up to NB bytes, LSB first.
  task automatic decode_stream(output logic [WIDTH-1:0] ed, output bit ee);
    logic [8*NB-1:0] acc;
    logic [7:0]      b;
    int              n;
    int              i;
    acc = '0;
    ee  = 1'b0;
    n   = 0;
    i   = 0;
    while (n < NB && i < rx_model.size()) begin
      b = rx_model[i];
      i++;
      if (b == ESC) begin
        if (i >= rx_model.size()) break;
        if (rx_model[i] != ESC) begin
          ee = 1'b1;
          break;
        end
        i++;
      end
      acc[8*n +: 8] = b;
      n++;
    end
    ed = acc[WIDTH-1:0];
  endtask

  // ---------------------------------------------------------------------------
  // Host-side drivers
  // ---------------------------------------------------------------------------
  int got_lat;

  task automatic send_req(input bit wr, input logic [4:0] a, input logic [WIDTH-1:0] d);
    int waited;
    @(negedge clk);
    req_write_i   = wr;
    req_address_i = a;
    req_data_i    = d;
    req_valid_i   = 1'b1;
    waited = 0;
    while (!req_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    check("req_ready_busy", 64'(req_ready_o), 64'd0);
  endtask

  task automatic wait_rsp(input string tag, input int hold,
                          input logic [WIDTH-1:0] ed, input bit ee);
    int n;
    n = 0;
    while (!rsp_valid_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    got_lat = n;
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd1);
    check({tag, "_rsp_data"},  64'(rsp_data_o),  64'(ed));
    check({tag, "_rsp_error"}, 64'(rsp_error_o), 64'(ee));
    if (rsp_valid_o) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 64'(rsp_valid_o), 64'd1);
        check({tag, "_hold_data"},  64'(rsp_data_o),  64'(ed));
      end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      @(negedge clk);
      check({tag, "_ready_back"}, 64'(req_ready_o), 64'd1);
      check({tag, "_valid_drop"}, 64'(rsp_valid_o), 64'd0);
    end
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_tx_len"}, 64'(tx_got.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 64'(tx_got[i]), 64'(exp_tx[i]));
  endtask

  task automatic start_txn();
    tx_got.delete();
    rx_pend.delete();
    flush_gen++;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed table: {request, RX stream, expected TX frame, expected response}
  // Byte streams are written first byte leftmost in an 80-bit field.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic             wr;
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
    logic [79:0]      rx;
    int               rx_n;
    logic [79:0]      tx;
    int               tx_n;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ed;
    bit               ee;
    bit               wr;
    logic [4:0]       a;
    logic [8*NB-1:0]  p;
    logic [7:0]       b;
    bit               inj;
    int               inj_at;
    string            tag;

    vecs[0] = '{1'b1, 5'h11, 41'h0_1234_5678, 80'h0, 0,
                80'hB1_51_78_56_34_12_00_00_00_00, 8, 41'h0, 1'b0};
    vecs[1] = '{1'b1, 5'h02, 41'h0B1, 80'h0, 0,
                80'hB1_42_B1_B1_00_00_00_00_00_00, 9, 41'h0, 1'b0};
    vecs[2] = '{1'b0, 5'h11, 41'h0, 80'h78_56_34_B1_B1_00_00_00_00_00, 7,
                80'hB1_31_00_00_00_00_00_00_00_00, 2, 41'h0_B134_5678, 1'b0};
    vecs[3] = '{1'b0, 5'h03, 41'h0, 80'h12_B1_07_00_00_00_00_00_00_00, 3,
                80'hB1_23_00_00_00_00_00_00_00_00, 2, 41'h12, 1'b1};
    vecs[4] = '{1'b0, 5'h03, 41'h0, 80'hFF_FF_FF_FF_FF_B1_B1_00_00_00, 7,
                80'hB1_23_00_00_00_00_00_00_00_00, 2, 41'h1FF_FFFF_FFFF, 1'b0};
    vecs[5] = '{1'b1, 5'h1F, 41'h1FF_FFFF_FFFF, 80'h0, 0,
                80'hB1_5F_FF_FF_FF_FF_FF_01_00_00, 8, 41'h0, 1'b0};

    rst_ni        = 1'b0;
    req_valid_i   = 1'b0;
    req_write_i   = 1'b0;
    req_address_i = '0;
    req_data_i    = '0;
    rsp_ready_i   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_data",  64'(rsp_data_o),  64'd0);
    check("rst_rsp_error", 64'(rsp_error_o), 64'd0);
    check("rst_we",        64'(we_o),        64'd0);
    check("rst_re",        64'(re_o),        64'd0);
    check("rst_dsend",     64'(dsend_o),     64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table, UART always ready.
    rnd_ready = 1'b0;
    for (int v = 0; v < 6; v++) begin
      tag = $sformatf("vec%0d", v);
      start_txn();
      for (int i = 0; i < vecs[v].rx_n; i++) rx_pend.push_back(vecs[v].rx[79-8*i -: 8]);
      exp_tx.delete();
      for (int i = 0; i < vecs[v].tx_n; i++) exp_tx.push_back(vecs[v].tx[79-8*i -: 8]);
      send_req(vecs[v].wr, vecs[v].addr, vecs[v].data);
      wait_rsp(tag, 3, vecs[v].exp_data, vecs[v].exp_err);
      cmp_frame(tag);
    end

    // Reset during the third write payload byte.
    start_txn();
    send_req(1'b1, 5'h04, 41'h0_AABB_CCDD);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (tx_got.size() == 5 && we_o) break;
    end
    check("mid_rst_reached", 64'(tx_got.size()), 64'd5);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_we",        64'(we_o),        64'd0);
    check("mid_rst_re",        64'(re_o),        64'd0);
    check("mid_rst_dsend",     64'(dsend_o),     64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("mid_rst_rsp_data",  64'(rsp_data_o),  64'd0);
    @(negedge clk);
    tx_got.delete();
    rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready_o),   64'd1);
    check("post_rst_no_rsp",    64'(rsp_valid_o),   64'd0);
    check("post_rst_no_tx",     64'(tx_got.size()), 64'd0);
    start_txn();
    build_frame(1'b1, 5'h09, 41'h0_00B1_2345);
    send_req(1'b1, 5'h09, 41'h0_00B1_2345);
    wait_rsp("post_rst_wr", 1, 41'h0, 1'b0);
    cmp_frame("post_rst_wr");

`ifdef DMI_UART_HOST_TIMEOUT_EN
    // Read with no RX bytes ends in a timeout error.
    start_txn();
    build_frame(1'b0, 5'h05, 41'h0);
    send_req(1'b0, 5'h05, 41'h0);
    wait_rsp("timeout", 1, 41'h0, 1'b1);
    check("timeout_latency", 64'(got_lat >= TO && got_lat <= TO + 10), 64'd1);
    cmp_frame("timeout");
`else
    // Read with no RX bytes waits; it completes once bytes show up.
    start_txn();
    build_frame(1'b0, 5'h05, 41'h0);
    send_req(1'b0, 5'h05, 41'h0);
    repeat (300) @(negedge clk);
    check("wait_no_rsp", 64'(rsp_valid_o), 64'd0);
    rx_model = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
    foreach (rx_model[i]) rx_pend.push_back(rx_model[i]);
    decode_stream(ed, ee);
    wait_rsp("wait_rd", 1, ed, ee);
    cmp_frame("wait_rd");
`endif

    // Randomized transactions against the model, UART readiness random.
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tag = $sformatf("rnd%0d", t);
      start_txn();
      wr = 1'(($urandom_range(0, 1)));
      a  = 5'($urandom);
      for (int k = 0; k < NB; k++)
        p[8*k +: 8] = ($urandom_range(0, 3) == 0) ? ESC : 8'($urandom);
      d = p[WIDTH-1:0];
      build_frame(wr, a, d);
      if (wr) begin
        ed = '0;
        ee = 1'b0;
      end else begin
        rx_model.delete();
        inj    = ($urandom_range(0, 5) == 0);
        inj_at = $urandom_range(0, NB - 1);
        for (int k = 0; k < NB; k++) begin
          if (inj && k == inj_at) begin
            b = 8'($urandom);
            if (b == ESC) b = 8'h00;
            rx_model.push_back(ESC);
            rx_model.push_back(b);
            break;
          end
          rx_model.push_back(p[8*k +: 8]);
          if (p[8*k +: 8] == ESC) rx_model.push_back(ESC);
        end
        foreach (rx_model[i]) rx_pend.push_back(rx_model[i]);
        decode_stream(ed, ee);
      end
      send_req(wr, a, d);
      wait_rsp(tag, $urandom_range(0, 3), ed, ee);
      cmp_frame(tag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
